// File: rtl/centipede_pkg.sv
// Shared types and helpers for the Centipede trackball sequencer.
// Holds the per-axis FSM state enum and the saturating add helper.
package centipede_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIR_SETUP,
        STEPPING
    } axis_state_e;

    // Add a and b, clamping the result to +/-lim.
    function automatic int sat_add(
        input int a,
        input int b,
        input int lim
    );
        int s;
        s = a + b;
        if (s > lim)  return lim;
        if (s < -lim) return -lim;
        return s;
    endfunction

endpackage

// File: rtl/trak_axis_seq.sv
// One trackball axis: saturating accumulator drained as rate-limited steps.
// Ports: clk_i/rst_i (sync, active-high), event_i, delta_i (9-bit signed),
//        flip_i (negate delta), dir_o/qclk_o (axis pins), busy_o (not idle).
module trak_axis_seq
    import centipede_pkg::*;
#(
    parameter int ACC_W    = 12,
    parameter int STEP_DIV = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       event_i,
    input  logic [8:0] delta_i,
    input  logic       flip_i,
    output logic       dir_o,
    output logic       qclk_o,
    output logic       busy_o
);

    localparam int DIV_W   = $clog2(STEP_DIV);
    localparam int ACC_MAX = 2 ** (ACC_W - 1) - 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(STEP_DIV - 1);

    axis_state_e              state_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [DIV_W-1:0]         div_q;
    logic                     dir_q;
    logic                     qclk_q;

    logic signed [8:0] d9;
    logic              acc_nz;
    logic              want;
    logic              step;
    int                dval;
    int                sval;
    int                acc_d;

    assign d9     = signed'(delta_i);
    assign acc_nz = (acc_q != '0);
    assign want   = ~acc_q[ACC_W-1];

    // A step only happens in the current direction; IDLE steps at once,
    // the other states wait for the divider to expire.
    assign step = acc_nz && (want == dir_q)
               && ((state_q == IDLE) || (div_q == '0));

    always_comb begin
        dval = 0;
        sval = 0;
        if (event_i) dval = flip_i ? -int'(d9) : int'(d9);
        if (step)    sval = dir_q ? 1 : -1;
        // Packet and step share one saturating add so nothing is dropped.
        acc_d = sat_add(int'(acc_q), dval - sval, ACC_MAX);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            div_q   <= '0;
            dir_q   <= 1'b0;
            qclk_q  <= 1'b0;
        end else begin
            acc_q <= acc_d[ACC_W-1:0];
            if (step) begin
                qclk_q  <= ~qclk_q;
                div_q   <= DIV_RELOAD;
                state_q <= STEPPING;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (acc_nz) begin
                            dir_q   <= want;
                            div_q   <= DIV_RELOAD;
                            state_q <= DIR_SETUP;
                        end
                    end
                    DIR_SETUP, STEPPING: begin
                        if (div_q != '0) begin
                            div_q <= div_q - 1'b1;
                        end else if (!acc_nz) begin
                            state_q <= IDLE;
                        end else begin
                            // Reversal: hold off a full setup interval.
                            dir_q   <= want;
                            div_q   <= DIV_RELOAD;
                            state_q <= DIR_SETUP;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign dir_o  = dir_q;
    assign qclk_o = qclk_q;
    assign busy_o = acc_nz | (state_q != IDLE);

endmodule

// File: rtl/trakball_quad_ctrl.sv
// PS/2 mouse packets to the Centipede 4-bit trackball bus.
// Ports: clk_sys, reset (sync, active-high), ps2_mouse (hps_io bus),
//        flip (negate deltas), trak_o {dir_x,clk_x,dir_y,clk_y}, busy_o.
module trakball_quad_ctrl
    import centipede_pkg::*;
#(
    parameter int ACC_W    = 12,
    parameter int STEP_DIV = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [24:0] ps2_mouse,
    input  logic        flip,
    output logic [3:0]  trak_o,
    output logic        busy_o
);

    logic       old_t_q;
    logic       busy_q;
    logic       evt;
    logic [8:0] dx;
    logic [8:0] dy;
    logic       dir_x, clk_x, bsy_x;
    logic       dir_y, clk_y, bsy_y;
    logic       unused_bits;

    assign evt = ps2_mouse[24] ^ old_t_q;
    assign dx  = {ps2_mouse[4], ps2_mouse[15:8]};
    assign dy  = {ps2_mouse[5], ps2_mouse[23:16]};

    assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:0]};

    // old_t tracks the toggle during reset so release causes no event.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            old_t_q <= ps2_mouse[24];
            busy_q  <= 1'b0;
        end else begin
            old_t_q <= ps2_mouse[24];
            busy_q  <= bsy_x | bsy_y;
        end
    end

    trak_axis_seq #(
        .ACC_W    (ACC_W),
        .STEP_DIV (STEP_DIV)
    ) u_x (
        .clk_i   (clk_sys),
        .rst_i   (reset),
        .event_i (evt),
        .delta_i (dx),
        .flip_i  (flip),
        .dir_o   (dir_x),
        .qclk_o  (clk_x),
        .busy_o  (bsy_x)
    );

    trak_axis_seq #(
        .ACC_W    (ACC_W),
        .STEP_DIV (STEP_DIV)
    ) u_y (
        .clk_i   (clk_sys),
        .rst_i   (reset),
        .event_i (evt),
        .delta_i (dy),
        .flip_i  (flip),
        .dir_o   (dir_y),
        .qclk_o  (clk_y),
        .busy_o  (bsy_y)
    );

    assign trak_o = {dir_x, clk_x, dir_y, clk_y};
    assign busy_o = busy_q;

endmodule

// File: tb/tb_trakball_quad_ctrl.sv
// Directed bench for trakball_quad_ctrl with STEP_DIV=4, ACC_W=12.
// Logs pin activity per edge and checks against hand-computed timings.
module tb_trakball_quad_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [24:0] ps2_mouse = '0;
    logic        flip = 1'b0;
    logic [3:0]  trak_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [3:0] prev = '0;
    logic [3:0] trak_log[int];
    logic       busy_log[int];
    int xtog[$];
    int ytog[$];
    int xdir[$];
    int ydir[$];

    trakball_quad_ctrl #(
        .ACC_W    (12),
        .STEP_DIV (4)
    ) dut (
        .clk_sys   (clk),
        .reset     (reset),
        .ps2_mouse (ps2_mouse),
        .flip      (flip),
        .trak_o    (trak_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample 1 ns after each edge; cyc then equals the edge number.
    always @(posedge clk) begin
        #1;
        trak_log[cyc] = trak_o;
        busy_log[cyc] = busy_o;
        if (trak_o[3] != prev[3]) xdir.push_back(cyc);
        if (trak_o[2] != prev[2]) xtog.push_back(cyc);
        if (trak_o[1] != prev[1]) ydir.push_back(cyc);
        if (trak_o[0] != prev[0]) ytog.push_back(cyc);
        prev = trak_o;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int trak_at(input int c);
        return trak_log.exists(c) ? int'(trak_log[c]) : -1;
    endfunction

    function automatic int busy_at(input int c);
        return busy_log.exists(c) ? int'(busy_log[c]) : -1;
    endfunction

    task automatic clear_logs();
        xtog.delete();
        ytog.delete();
        xdir.delete();
        ydir.delete();
        trak_log.delete();
        busy_log.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic send(input int dx, input int dy, output int t);
        logic [31:0] vx;
        logic [31:0] vy;
        @(negedge clk);
        vx = dx;
        vy = dy;
        ps2_mouse[15:8]  = vx[7:0];
        ps2_mouse[4]     = vx[8];
        ps2_mouse[23:16] = vy[7:0];
        ps2_mouse[5]     = vy[8];
        ps2_mouse[24]    = ~ps2_mouse[24];
        t = cyc + 1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (busy_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) check("idle_timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int t, t0, tl, r, n, bad;

        // 1: toggle bit high and a delta present while in reset
        repeat (3) @(negedge clk);
        ps2_mouse[24]   = 1'b1;
        ps2_mouse[15:8] = 8'd5;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_logs();
        repeat (50) @(negedge clk);
        bad = 0;
        foreach (trak_log[k]) if (trak_log[k] != 0 || busy_log[k]) bad++;
        check("rst_quiet", bad, 0);
        check("rst_toggles", xtog.size() + ytog.size(), 0);

        // 2: dx=+3 from reset, needs a direction change first
        do_reset();
        send(3, 0, t);
        wait_idle(200);
        check("px_dir_pre", trak_at(t), 0);
        check("px_dir_n", xdir.size(), 1);
        check("px_dir_t", xdir.size() > 0 ? xdir[0] : -1, t + 1);
        check("px_tog_n", xtog.size(), 3);
        check("px_tog0", xtog.size() > 0 ? xtog[0] : -1, t + 5);
        check("px_tog1", xtog.size() > 1 ? xtog[1] : -1, t + 9);
        check("px_tog2", xtog.size() > 2 ? xtog[2] : -1, t + 13);
        check("px_busy17", busy_at(t + 17), 1);
        check("px_busy18", busy_at(t + 18), 0);
        check("px_y_quiet", ytog.size() + ydir.size(), 0);

        // 3: dy=-2 from reset, direction already matches
        do_reset();
        send(0, -2, t);
        wait_idle(200);
        check("ny_tog_n", ytog.size(), 2);
        check("ny_tog0", ytog.size() > 0 ? ytog[0] : -1, t + 1);
        check("ny_tog1", ytog.size() > 1 ? ytog[1] : -1, t + 5);
        check("ny_dir", ydir.size(), 0);
        check("ny_x_quiet", xtog.size(), 0);

        // 4: 20 packets of +255 every 2 cycles, clamps at 2047
        do_reset();
        t0 = 0;
        tl = 0;
        for (int i = 0; i < 20; i++) begin
            send(255, 0, t);
            if (i == 0) t0 = t;
            tl = t;
            @(negedge clk);
        end
        wait_idle(12000);
        check("sat_last_t", tl - t0, 38);
        n = 0;
        foreach (xtog[i]) if (xtog[i] <= tl) n++;
        check("sat_burst", n, 9);
        check("sat_after", xtog.size() - n, 2047);
        check("sat_dir_n", xdir.size(), 1);
        check("sat_dir", int'(trak_o[3]), 1);

        // 5: flip negates dx=+1 into one negative step
        do_reset();
        flip = 1'b1;
        send(1, 0, t);
        wait_idle(200);
        flip = 1'b0;
        check("flip_tog_n", xtog.size(), 1);
        check("flip_tog0", xtog.size() > 0 ? xtog[0] : -1, t + 1);
        check("flip_dir", trak_at(t + 1) >>> 3, 0);

        // 6a: +10 then -20 after three steps
        do_reset();
        send(10, 0, t);
        n = 0;
        while (xtog.size() < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rev_wait", xtog.size(), 3);
        send(-20, 0, t);
        wait_idle(500);
        check("rev_tog_n", xtog.size(), 16);
        check("rev_dir_n", xdir.size(), 2);
        check("rev_gap",
              (xtog.size() > 3 && xdir.size() > 1) ? xtog[3] - xdir[1] : -1,
              4);
        check("rev_dir", int'(trak_o[3]), 0);

        // 6b: reset in the middle of a stream
        do_reset();
        send(-20, 0, t);
        n = 0;
        while (xtog.size() < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        r = cyc + 1;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        n = 0;
        foreach (xtog[i]) if (xtog[i] > r) n++;
        check("mid_trak", trak_at(r), 0);
        check("mid_busy", busy_at(r), 0);
        check("mid_tog_after", n, 0);
        check("mid_busy_end", int'(busy_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
